adc_controller_rx: RTL and testbench

- I2S receive master for the codec ADC path; the capture-side counterpart of the DAC transmit controller.
- Generates mclk/sclk/lrck for the ADC from the PLL clock, then deserializes sdata_adc into 24-bit left and right samples.
- Presents each stereo pair with a one-cycle valid strobe for downstream processing or loopback to the DAC controller.

---
 rtl/adc_controller_rx.sv | 113 +++++++++++
 tb/tb_adc_controller_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/adc_controller_rx.sv
// adc_controller_rx: I2S receive master that generates mclk/sclk/lrck and deserializes the ADC
// data line into left/right samples. Define ADC_LEFT_JUSTIFIED_EN to select left-justified slot mapping.
module adc_controller_rx #(
    parameter int DATA_W      = 24,
    parameter int SCLK_HALF   = 2,
    parameter int BITS_PER_CH = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mclk_adc,
    output logic              sclk_adc,
    output logic              lrck_adc,
    input  logic              sdata_adc,
    output logic [DATA_W-1:0] data_adc_chL,
    output logic [DATA_W-1:0] data_adc_chR,
    output logic              data_valid
);

    typedef enum logic {
        S_LEFT  = 1'b0,
        S_RIGHT = 1'b1
    } state_t;

    localparam int DIV_W = (2 * SCLK_HALF > 1) ? $clog2(2 * SCLK_HALF) : 1;
    localparam int BIT_W = $clog2(BITS_PER_CH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCLK_HALF - 1);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(SCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_CH - 1);
`ifdef ADC_LEFT_JUSTIFIED_EN
    localparam logic [BIT_W-1:0] LAST_K = BIT_W'(DATA_W - 1);
`else
    localparam logic [BIT_W-1:0] LAST_K = BIT_W'(DATA_W);
`endif

    state_t              state;
    state_t              state_next;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   hold_l;
    logic [DATA_W-1:0]   word;
    logic                xfer_pend;
    logic                sample_pt;
    logic                fall_pt;
    logic                in_window;
    logic                load_l;
    logic                load_r;

    // sample_pt is the clk edge on which sclk rises; fall_pt is the edge on which it falls.
    assign sample_pt = (div_cnt == DIV_RISE);
    assign fall_pt   = (div_cnt == DIV_LAST);
    assign word      = {shift_reg[DATA_W-2:0], sdata_adc};
    assign lrck_adc  = (state == S_RIGHT);

`ifdef ADC_LEFT_JUSTIFIED_EN
    assign in_window = (bit_cnt <= LAST_K);
`else
    assign in_window = (bit_cnt != '0) && (bit_cnt <= LAST_K);
`endif

    always_comb begin
        state_next = state;
        load_l     = 1'b0;
        load_r     = 1'b0;
        if (fall_pt && (bit_cnt == BIT_LAST)) begin
            state_next = (state == S_LEFT) ? S_RIGHT : S_LEFT;
        end
        if (sample_pt && (bit_cnt == LAST_K)) begin
            if (state == S_LEFT) load_l = 1'b1;
            else                 load_r = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_LEFT;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            mclk_adc <= 1'b0;
            sclk_adc <= 1'b0;
        end else begin
            state    <= state_next;
            mclk_adc <= ~mclk_adc;
            div_cnt  <= fall_pt ? '0 : div_cnt + 1'b1;
            if (sample_pt)    sclk_adc <= 1'b1;
            else if (fall_pt) sclk_adc <= 1'b0;
            if (fall_pt) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end
    end

    // data_valid is a one-clk strobe with no ready: the pair on data_adc_chL/R is
    // valid in that cycle and holds until the next strobe overwrites it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg    <= '0;
            hold_l       <= '0;
            xfer_pend    <= 1'b0;
            data_adc_chL <= '0;
            data_adc_chR <= '0;
            data_valid   <= 1'b0;
        end else begin
            if (sample_pt && in_window) shift_reg <= word;
            if (load_l) hold_l <= word;
            xfer_pend  <= load_r;
            data_valid <= xfer_pend;
            if (xfer_pend) begin
                data_adc_chL <= hold_l;
                data_adc_chR <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_adc_controller_rx.sv
// Self-checking bench for adc_controller_rx: table of stereo frames driven by an ADC model,
// a negedge monitor with an expected-pair queue, plus reset sequences.
module tb_adc_controller_rx;

    localparam int DATA_W = 24;
`ifdef ADC_LEFT_JUSTIFIED_EN
    localparam int VALID_OFF = 223;
`else
    localparam int VALID_OFF = 227;
`endif

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        fill;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              sdata_adc;
    logic              mclk_adc;
    logic              sclk_adc;
    logic              lrck_adc;
    logic [DATA_W-1:0] data_adc_chL;
    logic [DATA_W-1:0] data_adc_chR;
    logic              data_valid;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                n_pulses = 0;
    int                cyc;
    logic [23:0]       last_l = '0;
    logic [23:0]       last_r = '0;
    logic [47:0]       exp_q[$];
    vec_t              vecs[9];

    adc_controller_rx dut (
        .clk          (clk),
        .rst          (rst),
        .mclk_adc     (mclk_adc),
        .sclk_adc     (sclk_adc),
        .lrck_adc     (lrck_adc),
        .sdata_adc    (sdata_adc),
        .data_adc_chL (data_adc_chL),
        .data_adc_chR (data_adc_chR),
        .data_valid   (data_valid)
    );

    // clock / reset-relative cycle count
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
        end
    endtask

    function automatic logic slot_bit(input logic [23:0] w, input logic fill, input int k);
`ifdef ADC_LEFT_JUSTIFIED_EN
        if (k < 24) return w[23-k];
`else
        if (k >= 1 && k <= 24) return w[24-k];
`endif
        return fill;
    endfunction

    // ADC model: called #1 after a frame-start edge, changes data once per sclk period
    task automatic drive_slots(input logic [23:0] l, input logic [23:0] r, input logic fill,
                               input int n_slots);
        for (int i = 0; i < n_slots; i++) begin
            sdata_adc = slot_bit((i < 32) ? l : r, fill, i % 32);
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_frame(input vec_t v);
        exp_q.push_back({v.exp_l, v.exp_r});
        drive_slots(v.l, v.r, v.fill, 64);
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sdata_adc = ~sdata_adc;
            check("rst_chL", data_adc_chL, 0);
            check("rst_chR", data_adc_chR, 0);
            check("rst_valid", data_valid, 0);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_mclk", mclk_adc, 0);
            check("rst_sclk", sclk_adc, 0);
            check("rst_lrck", lrck_adc, 0);
            check("rst_valid_mon", data_valid, 0);
        end else begin
            check("mclk", mclk_adc, cyc % 2);
            check("sclk", sclk_adc, ((cyc % 4) >= 2) ? 1 : 0);
            check("lrck", lrck_adc, (cyc / 128) % 2);
            check("valid_timing", data_valid, ((cyc % 256) == VALID_OFF) ? 1 : 0);
            if (data_valid) begin
                n_pulses++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pair", 1, 0);
                end else begin
                    logic [47:0] e;
                    e = exp_q.pop_front();
                    check("chL", data_adc_chL, e[47:24]);
                    check("chR", data_adc_chR, e[23:0]);
                    last_l = e[47:24];
                    last_r = e[23:0];
                end
            end else begin
                check("chL_hold", data_adc_chL, last_l);
                check("chR_hold", data_adc_chR, last_r);
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 1'b0, 24'hA5A5A5, 24'h5A5A5A};
        vecs[1] = '{24'h800000, 24'h7FFFFF, 1'b1, 24'h800000, 24'h7FFFFF};
        vecs[2] = '{24'hC00001, 24'h000003, 1'b0, 24'hC00001, 24'h000003};
        vecs[3] = '{24'h000001, 24'hFFFFFE, 1'b1, 24'h000001, 24'hFFFFFE};
        vecs[4] = '{24'h000002, 24'hFFFFFD, 1'b0, 24'h000002, 24'hFFFFFD};
        vecs[5] = '{24'h000003, 24'hFFFFFC, 1'b1, 24'h000003, 24'hFFFFFC};
        vecs[6] = '{24'h000004, 24'hFFFFFB, 1'b0, 24'h000004, 24'hFFFFFB};
        vecs[7] = '{24'h123456, 24'h654321, 1'b1, 24'h123456, 24'h654321};
        vecs[8] = '{24'h0F0F0F, 24'hF0F0F0, 1'b1, 24'h0F0F0F, 24'hF0F0F0};

        rst       = 1'b1;
        sdata_adc = 1'b0;
        #2 rst = 1'b0;
        hold_reset(10);

        // release #1 after an edge; the next edge is slot 0 of the left channel
        rst = 1'b1;
        for (int f = 0; f < 7; f++) drive_frame(vecs[f]);

        // abort inside right-channel slot k=12
        drive_slots(24'h111111, 24'h222222, 1'b0, 44);
        sdata_adc = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_chL", data_adc_chL, 0);
        check("midrst_chR", data_adc_chR, 0);
        check("midrst_valid", data_valid, 0);
        last_l = '0;
        last_r = '0;
        hold_reset(5);

        rst = 1'b1;
        drive_frame(vecs[7]);
        drive_frame(vecs[8]);

        check("pulse_count", n_pulses, 9);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
